// File: rtl/stack_pkg.sv
// Shared types and constants for the stack sequencer/arbiter slice.
package stack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT,
        REJECT
    } stack_state_t;

    localparam logic OP_PUSH    = 1'b0;
    localparam logic OP_POP     = 1'b1;
    localparam int   RD_LATENCY = 1;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic ptrQ;
    logic ptrD;

    // ptrQ names the requester that wins the next tie; it moves away from whoever was just served.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptrQ ? 2'b10 : 2'b01;
        end
    end

    assign ptrD = (advance_i && (gnt_o != 2'b00)) ? gnt_o[0] : ptrQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptrQ <= 1'b0;
        end else begin
            ptrQ <= ptrD;
        end
    end

endmodule

// File: rtl/stack_arbiter_ctrl.sv
// Stack RAM sequencer shared by the control unit (req 0) and interrupt unit (req 1).
// Optional high-water-mark tracking is enabled with `define STACK_WATERMARK_EN.
module stack_arbiter_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [1:0]          req,
    input  logic [1:0]          op,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_we,
    output logic                mem_re,
    output logic [AW-1:0]       mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [AW:0]         sp,
    output logic                is_full,
    output logic                is_empty
`ifdef STACK_WATERMARK_EN
    ,
    input  logic                hwm_clr,
    output logic [AW:0]         hwm
`endif
);

    localparam logic [AW:0] FULL_SP = (AW+1)'(DEPTH);

    stack_state_t        stateQ, stateD;
    logic [AW:0]         spQ, spD;
    logic                winQ, winD;
    logic [1:0]          gntQ, gntD;
    logic [1:0]          doneQ, doneD;
    logic                errQ, errD;
    logic                memWeQ, memWeD;
    logic                memReQ, memReD;
    logic [AW-1:0]       memAddrQ, memAddrD;
    logic [DATA_W-1:0]   memWdataQ, memWdataD;
    logic [DATA_W-1:0]   rdataQ, rdataD;
    logic [1:0]          arbGnt;
    logic                arbAdvance;
    logic                arbWin;
    logic [DATA_W-1:0]   winData;

    assign arbAdvance = (stateQ == IDLE) && !flush && (req != 2'b00);
    assign arbWin     = arbGnt[1];
    assign winData    = arbWin ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    rr_arbiter2 uArb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .advance_i (arbAdvance),
        .gnt_o     (arbGnt)
    );

    always_comb begin
        stateD    = stateQ;
        spD       = spQ;
        winD      = winQ;
        gntD      = 2'b00;
        doneD     = 2'b00;
        errD      = 1'b0;
        memWeD    = 1'b0;
        memReD    = 1'b0;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        rdataD    = rdataQ;
        case (stateQ)
            IDLE: begin
                if (req != 2'b00) begin
                    winD = arbWin;
                    gntD = arbGnt;
                    if ((op[arbWin] == OP_PUSH && spQ == FULL_SP) ||
                        (op[arbWin] == OP_POP && spQ == '0)) begin
                        stateD = REJECT;
                        doneD  = arbGnt;
                        errD   = 1'b1;
                    end else if (op[arbWin] == OP_PUSH) begin
                        stateD    = WRITE;
                        doneD     = arbGnt;
                        memWeD    = 1'b1;
                        memAddrD  = spQ[AW-1:0];
                        memWdataD = winData;
                    end else begin
                        stateD   = READ;
                        memReD   = 1'b1;
                        memAddrD = AW'(spQ - 1'b1);
                    end
                end
            end
            WRITE: begin
                spD    = spQ + 1'b1;
                stateD = IDLE;
            end
            READ: begin
                spD    = spQ - 1'b1;
                doneD  = onehot2(winQ);
                stateD = READ_WAIT;
            end
            READ_WAIT: begin
                rdataD = mem_rdata;
                stateD = IDLE;
            end
            REJECT: stateD = IDLE;
            default: stateD = IDLE;
        endcase
        // Flush wins over every transition; a flushed READ never reaches READ_WAIT.
        if (flush) begin
            stateD = IDLE;
            spD    = '0;
            gntD   = 2'b00;
            doneD  = 2'b00;
            errD   = 1'b0;
            memWeD = 1'b0;
            memReD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= IDLE;
            spQ       <= '0;
            winQ      <= 1'b0;
            gntQ      <= 2'b00;
            doneQ     <= 2'b00;
            errQ      <= 1'b0;
            memWeQ    <= 1'b0;
            memReQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            rdataQ    <= '0;
        end else begin
            stateQ    <= stateD;
            spQ       <= spD;
            winQ      <= winD;
            gntQ      <= gntD;
            doneQ     <= doneD;
            errQ      <= errD;
            memWeQ    <= memWeD;
            memReQ    <= memReD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            rdataQ    <= rdataD;
        end
    end

    // The RAM answers during READ_WAIT, so rdata forwards it there to line up with done.
    assign rdata     = (stateQ == READ_WAIT) ? mem_rdata : rdataQ;
    assign done      = doneQ | ((flush && stateQ == READ) ? onehot2(winQ) : 2'b00);
    assign err       = errQ | (flush && stateQ != IDLE);
    assign gnt       = gntQ;
    assign mem_we    = memWeQ;
    assign mem_re    = memReQ;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;
    assign sp        = spQ;
    assign is_full   = (spQ == FULL_SP);
    assign is_empty  = (spQ == '0);

`ifdef STACK_WATERMARK_EN
    logic [AW:0] hwmQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwmQ <= '0;
        end else if (hwm_clr) begin
            hwmQ <= '0;
        end else if (spQ > hwmQ) begin
            hwmQ <= spQ;
        end
    end

    assign hwm = hwmQ;
`endif

endmodule

// File: tb/tb_stack_arbiter_ctrl.sv
// Randomized bench for stack_arbiter_ctrl against a queue-based stack model.
// Covers the watermark port when compiled with `define STACK_WATERMARK_EN.
module tb_stack_arbiter_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int AW     = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic [1:0]          req;
    logic [1:0]          op;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          gnt;
    logic [1:0]          done;
    logic                err;
    logic [DATA_W-1:0]   rdata;
    logic                mem_we;
    logic                mem_re;
    logic [AW-1:0]       mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic [AW:0]         sp;
    logic                is_full;
    logic                is_empty;
`ifdef STACK_WATERMARK_EN
    logic                hwm_clr;
    logic [AW:0]         hwm;
`endif

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] model [$];
    int                prefer;
    int                testsRun = 0;
    int                testsFailed = 0;

    always #5 clk = ~clk;

    stack_arbiter_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req       (req),
        .op        (op),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .sp        (sp),
        .is_full   (is_full),
        .is_empty  (is_empty)
`ifdef STACK_WATERMARK_EN
        ,
        .hwm_clr   (hwm_clr),
        .hwm       (hwm)
`endif
    );

    // External synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdleFlags();
        checkOutput("sp", 32'(sp), 32'(model.size()));
        checkOutput("isFull", 32'(is_full), 32'(model.size() == DEPTH));
        checkOutput("isEmpty", 32'(is_empty), 32'(model.size() == 0));
        checkOutput("idleDone", 32'(done), 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        req = 2'b00;
        op = 2'b00;
        wdata = '0;
        flush = 1'b0;
`ifdef STACK_WATERMARK_EN
        hwm_clr = 1'b0;
`endif
        model.delete();
        prefer = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One request from the mask; the model decides winner, outcome and expected data.
    task automatic applyStimulus(input logic [1:0] mask, input logic [1:0] ops,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        int w;
        int sz;
        logic isPop;
        logic rej;
        logic [1:0] expG;
        logic [DATA_W-1:0] wd;
        w = (mask == 2'b11) ? prefer : (mask[1] ? 1 : 0);
        prefer = 1 - w;
        expG = (w == 1) ? 2'b10 : 2'b01;
        isPop = ops[w];
        wd = (w == 1) ? d1 : d0;
        sz = model.size();
        rej = isPop ? (sz == 0) : (sz == DEPTH);
        req = mask;
        op = ops;
        wdata = {d1, d0};
        @(negedge clk);
        req = 2'b00;
        checkOutput("gnt", 32'(gnt), 32'(expG));
        if (rej) begin
            checkOutput("rejDone", 32'(done), 32'(expG));
            checkOutput("rejErr", 32'(err), 32'd1);
            checkOutput("rejWe", 32'(mem_we), 32'd0);
            checkOutput("rejRe", 32'(mem_re), 32'd0);
        end else if (!isPop) begin
            checkOutput("pushDone", 32'(done), 32'(expG));
            checkOutput("pushErr", 32'(err), 32'd0);
            checkOutput("pushWe", 32'(mem_we), 32'd1);
            checkOutput("pushAddr", 32'(mem_addr), 32'(sz % DEPTH));
            checkOutput("pushData", 32'(mem_wdata), 32'(wd));
            model.push_back(wd);
        end else begin
            checkOutput("popEarlyDone", 32'(done), 32'd0);
            checkOutput("popRe", 32'(mem_re), 32'd1);
            checkOutput("popAddr", 32'(mem_addr), 32'((sz - 1) % DEPTH));
            @(negedge clk);
            checkOutput("popDone", 32'(done), 32'(expG));
            checkOutput("popErr", 32'(err), 32'd0);
            checkOutput("popData", 32'(rdata), 32'(model[$]));
            checkOutput("popGntLow", 32'(gnt), 32'd0);
            void'(model.pop_back());
        end
        @(negedge clk);
        checkIdleFlags();
    endtask

    initial begin
        int n;
        doReset();
        checkOutput("rstGnt", 32'(gnt), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstWe", 32'(mem_we), 32'd0);
        checkOutput("rstRe", 32'(mem_re), 32'd0);
        checkOutput("rstRdata", 32'(rdata), 32'd0);
        checkIdleFlags();

        $display("[TB] single push, fill, overflow, drain, underflow");
        applyStimulus(2'b01, 2'b00, 16'hA5A5, 16'h0000);
        void'(model.pop_back());
        doReset();
        for (int i = 1; i <= 5; i++) applyStimulus(2'b01, 2'b00, 16'(i), 16'hFFFF);
        checkOutput("fullAfter4", 32'(is_full), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(2'b01, 2'b01, 16'h0, 16'h0);

        $display("[TB] tie arbitration with req held");
        doReset();
        n = 0;
        req = 2'b11;
        op = 2'b00;
        wdata = {16'hBBBB, 16'hAAAA};
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                checkOutput("rrGnt", 32'(gnt), (prefer == 1) ? 32'd2 : 32'd1);
                model.push_back((prefer == 1) ? 16'hBBBB : 16'hAAAA);
                prefer = 1 - prefer;
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        checkOutput("rrCount", 32'(n), 32'd4);
        @(negedge clk);
        checkIdleFlags();
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 2'b11, 16'h0, 16'h0);

        $display("[TB] flush during READ_WAIT");
        applyStimulus(2'b01, 2'b00, 16'd7, 16'd0);
        applyStimulus(2'b01, 2'b00, 16'd9, 16'd0);
        req = 2'b01;
        op = 2'b01;
        @(negedge clk);
        req = 2'b00;
        checkOutput("flushRe", 32'(mem_re), 32'd1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        checkOutput("flushDone", 32'(done), 32'd1);
        checkOutput("flushErr", 32'(err), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        model.delete();
        prefer = 1;
        @(negedge clk);
        checkIdleFlags();
        applyStimulus(2'b01, 2'b01, 16'h0, 16'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(2'($urandom_range(1, 3)), 2'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("[TB] asynchronous reset mid-WRITE");
        while (model.size() == DEPTH) applyStimulus(2'b01, 2'b01, 16'h0, 16'h0);
        req = 2'b01;
        op = 2'b00;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("arstDone", 32'(done), 32'd0);
        checkOutput("arstWe", 32'(mem_we), 32'd0);
        checkOutput("arstSp", 32'(sp), 32'd0);
        checkOutput("arstEmpty", 32'(is_empty), 32'd1);
        doReset();

`ifdef STACK_WATERMARK_EN
        $display("[TB] watermark");
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 16'(i), 16'h0);
        for (int i = 0; i < 2; i++) applyStimulus(2'b01, 2'b01, 16'h0, 16'h0);
        checkOutput("hwmPeak", 32'(hwm), 32'd3);
        hwm_clr = 1'b1;
        @(negedge clk);
        hwm_clr = 1'b0;
        checkOutput("hwmCleared", 32'(hwm), 32'd0);
        @(negedge clk);
        checkOutput("hwmAfterClr", 32'(hwm), 32'(model.size()));
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
